// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator; new timing is applied only at a frame wrap.
// Define VTG_GENLOCK_EN to add ext_vs_in, whose rising edge restarts the raster at (0,0).

module video_timing_gen #(
    parameter int                  H_BITS    = 12,
    parameter int                  V_BITS    = 11,
    parameter int                  FC_WIDTH  = 6,
    parameter int                  FPS       = 60,
    parameter bit                  HS_POL    = 1'b1,
    parameter bit                  VS_POL    = 1'b1,
    parameter logic [4*H_BITS-1:0] RST_CFG_H = {H_BITS'(1280), H_BITS'(110), H_BITS'(40), H_BITS'(220)},
    parameter logic [4*V_BITS-1:0] RST_CFG_V = {V_BITS'(720), V_BITS'(5), V_BITS'(5), V_BITS'(20)}
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    input  logic [4*H_BITS-1:0] cfg_h_in,
    input  logic [4*V_BITS-1:0] cfg_v_in,
    input  logic                cfg_valid_in,
`ifdef VTG_GENLOCK_EN
    input  logic                ext_vs_in,
`endif
    output logic                cfg_ready_out,
    output logic                cfg_err_out,
    output logic [H_BITS-1:0]   hcount_out,
    output logic [V_BITS-1:0]   vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_WIDTH-1:0] fc_out
);

    // Handshake: a config transfers on a rising edge where cfg_valid_in && cfg_ready_out.
    // Valid while ready is low is dropped, never queued.

    localparam int HT = H_BITS + 2;
    localparam int VT = V_BITS + 2;

    // Field index 3 = active, 2 = front porch, 1 = sync, 0 = back porch.
    function automatic logic [HT-1:0] h_fld(input logic [4*H_BITS-1:0] c, input int idx);
        return HT'(c[idx*H_BITS +: H_BITS]);
    endfunction

    function automatic logic [VT-1:0] v_fld(input logic [4*V_BITS-1:0] c, input int idx);
        return VT'(c[idx*V_BITS +: V_BITS]);
    endfunction

    function automatic logic [HT-1:0] h_sum(input logic [4*H_BITS-1:0] c);
        return h_fld(c, 3) + h_fld(c, 2) + h_fld(c, 1) + h_fld(c, 0);
    endfunction

    function automatic logic [VT-1:0] v_sum(input logic [4*V_BITS-1:0] c);
        return v_fld(c, 3) + v_fld(c, 2) + v_fld(c, 1) + v_fld(c, 0);
    endfunction

    logic [4*H_BITS-1:0] live_h_q, live_h_d, shadow_h_q, shadow_h_d;
    logic [4*V_BITS-1:0] live_v_q, live_v_d, shadow_v_q, shadow_v_d;
    logic                shadow_vld_q, shadow_vld_d;
    logic                ready_q, ready_d, err_q, err_d, started_q, started_d;
    logic [H_BITS-1:0]   hcount_q, hcount_d;
    logic [V_BITS-1:0]   vcount_q, vcount_d;
    logic                hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;
`ifdef VTG_GENLOCK_EN
    logic                ext_prev_q, ext_prev_d;
`endif

    logic [HT-1:0] h_tot_cur, h_tot_new, hs_start, hs_end;
    logic [VT-1:0] v_tot_cur, v_tot_new, vs_start, vs_end;
    logic          h_last, v_last, frame_end, resync, apply, accept, legal, hs_on, vs_on;

    always_comb begin
        h_tot_cur = h_sum(live_h_q);
        v_tot_cur = v_sum(live_v_q);
        h_last    = started_q && (HT'(hcount_q) == h_tot_cur - HT'(1));
        v_last    = VT'(vcount_q) == v_tot_cur - VT'(1);
        frame_end = h_last && v_last;
`ifdef VTG_GENLOCK_EN
        // Previous value resets high so a level held through reset is not an edge.
        resync     = started_q && ext_vs_in && !ext_prev_q;
        ext_prev_d = ext_vs_in;
`else
        resync = 1'b0;
`endif
        apply     = shadow_vld_q && (frame_end || resync);
        live_h_d  = apply ? shadow_h_q : live_h_q;
        live_v_d  = apply ? shadow_v_q : live_v_q;
        started_d = 1'b1;

        // First edge out of reset presents (0,0) rather than advancing past it.
        if (!started_q || resync || frame_end) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (h_last) begin
            hcount_d = '0;
            vcount_d = vcount_q + V_BITS'(1);
        end else begin
            hcount_d = hcount_q + H_BITS'(1);
            vcount_d = vcount_q;
        end

        // Decodes use the timing that will be live for the count being registered.
        hs_start = h_fld(live_h_d, 3) + h_fld(live_h_d, 2);
        hs_end   = hs_start + h_fld(live_h_d, 1);
        vs_start = v_fld(live_v_d, 3) + v_fld(live_v_d, 2);
        vs_end   = vs_start + v_fld(live_v_d, 1);
        hs_on    = (HT'(hcount_d) >= hs_start) && (HT'(hcount_d) < hs_end);
        vs_on    = (VT'(vcount_d) >= vs_start) && (VT'(vcount_d) < vs_end);
        hs_d     = (hs_on == HS_POL);
        vs_d     = (vs_on == VS_POL);
        ad_d     = (HT'(hcount_d) < h_fld(live_h_d, 3)) && (VT'(vcount_d) < v_fld(live_v_d, 3));
        nf_d     = (HT'(hcount_d) == h_fld(live_h_d, 3)) && (VT'(vcount_d) == v_fld(live_v_d, 3));

        if (nf_q) begin
            fc_d = (fc_q == FC_WIDTH'(FPS - 1)) ? '0 : fc_q + FC_WIDTH'(1);
        end else begin
            fc_d = fc_q;
        end

        h_tot_new = h_sum(cfg_h_in);
        v_tot_new = v_sum(cfg_v_in);
        legal     = (h_fld(cfg_h_in, 3) != '0) && (h_fld(cfg_h_in, 1) != '0) &&
                    (v_fld(cfg_v_in, 3) != '0) && (v_fld(cfg_v_in, 1) != '0) &&
                    (h_tot_new[HT-1 -: 2] == 2'b00) && (v_tot_new[VT-1 -: 2] == 2'b00);
        accept    = cfg_valid_in && ready_q;

        shadow_h_d   = shadow_h_q;
        shadow_v_d   = shadow_v_q;
        shadow_vld_d = shadow_vld_q && !apply;
        // Ready comes back one cycle after the shadow has been consumed.
        ready_d      = ready_q ? 1'b1 : !shadow_vld_q;
        err_d        = 1'b0;
        if (accept) begin
            if (legal) begin
                shadow_h_d   = cfg_h_in;
                shadow_v_d   = cfg_v_in;
                shadow_vld_d = 1'b1;
                ready_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            live_h_q     <= RST_CFG_H;
            live_v_q     <= RST_CFG_V;
            shadow_h_q   <= '0;
            shadow_v_q   <= '0;
            shadow_vld_q <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            started_q    <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            hs_q         <= !HS_POL;
            vs_q         <= !VS_POL;
            ad_q         <= 1'b0;
            nf_q         <= 1'b0;
            fc_q         <= '0;
`ifdef VTG_GENLOCK_EN
            ext_prev_q   <= 1'b1;
`endif
        end else begin
            live_h_q     <= live_h_d;
            live_v_q     <= live_v_d;
            shadow_h_q   <= shadow_h_d;
            shadow_v_q   <= shadow_v_d;
            shadow_vld_q <= shadow_vld_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            started_q    <= started_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            ad_q         <= ad_d;
            nf_q         <= nf_d;
            fc_q         <= fc_d;
`ifdef VTG_GENLOCK_EN
            ext_prev_q   <= ext_prev_d;
`endif
        end
    end

    assign cfg_ready_out = ready_q;
    assign cfg_err_out   = err_q;
    assign hcount_out    = hcount_q;
    assign vcount_out    = vcount_q;
    assign hs_out        = hs_q;
    assign vs_out        = vs_q;
    assign ad_out        = ad_q;
    assign nf_out        = nf_q;
    assign fc_out        = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 720p instance for line timing, legality and reset,
// and a second instance with a small reset mode for multi-frame, apply and frame-counter behaviour.

module tb_video_timing_gen;

    localparam int HB  = 12;
    localparam int VB  = 11;
    localparam int FW  = 6;
    localparam int FPS = 60;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } tmg_t;

    typedef struct {
        int h, v, fc;
        bit hs, vs, ad, nf, chk_rdy, rdy;
    } exp_t;

    typedef struct {
        logic [4*HB-1:0] ch;
        logic [4*VB-1:0] cv;
        bit              err;
    } vec_t;

    function automatic logic [4*HB-1:0] hv(input int a, input int f, input int s, input int b);
        return {HB'(a), HB'(f), HB'(s), HB'(b)};
    endfunction

    function automatic logic [4*VB-1:0] vv(input int a, input int f, input int s, input int b);
        return {VB'(a), VB'(f), VB'(s), VB'(b)};
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: default 720p reset timing.
    logic            r1_n, v1_valid;
    logic [4*HB-1:0] c1_h;
    logic [4*VB-1:0] c1_v;
    logic            rdy1, err1, hs1, vs1, ad1, nf1;
    logic [HB-1:0]   h1;
    logic [VB-1:0]   vc1;
    logic [FW-1:0]   fc1;

    // Instance 2: small reset timing 6/1/2/1 x 3/1/1/1.
    logic            r2_n, v2_valid;
    logic [4*HB-1:0] c2_h;
    logic [4*VB-1:0] c2_v;
    logic            rdy2, err2, hs2, vs2, ad2, nf2;
    logic [HB-1:0]   h2;
    logic [VB-1:0]   vc2;
    logic [FW-1:0]   fc2;

    video_timing_gen #(.H_BITS(HB), .V_BITS(VB), .FC_WIDTH(FW), .FPS(FPS)) dut1 (
        .pixel_clk_in (clk),
        .rst_n_in     (r1_n),
        .cfg_h_in     (c1_h),
        .cfg_v_in     (c1_v),
        .cfg_valid_in (v1_valid),
        .cfg_ready_out(rdy1),
        .cfg_err_out  (err1),
        .hcount_out   (h1),
        .vcount_out   (vc1),
        .hs_out       (hs1),
        .vs_out       (vs1),
        .ad_out       (ad1),
        .nf_out       (nf1),
        .fc_out       (fc1)
    );

    video_timing_gen #(.H_BITS(HB), .V_BITS(VB), .FC_WIDTH(FW), .FPS(FPS),
                       .RST_CFG_H({12'd6, 12'd1, 12'd2, 12'd1}),
                       .RST_CFG_V({11'd3, 11'd1, 11'd1, 11'd1})) dut2 (
        .pixel_clk_in (clk),
        .rst_n_in     (r2_n),
        .cfg_h_in     (c2_h),
        .cfg_v_in     (c2_v),
        .cfg_valid_in (v2_valid),
        .cfg_ready_out(rdy2),
        .cfg_err_out  (err2),
        .hcount_out   (h2),
        .vcount_out   (vc2),
        .hs_out       (hs2),
        .vs_out       (vs2),
        .ad_out       (ad2),
        .nf_out       (nf2),
        .fc_out       (fc2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    bit   chk_en  = 1'b0;
    bit   sel     = 1'b0;
    int   fc_m    = 0;
    bit   bump    = 1'b0;

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // Pushes the expected per-pixel outputs of lines [first, first+nl) for timing t.
    task automatic push_lines(input tmg_t t, input int first, input int nl, input bit applied);
        exp_t e;
        int   htot;
        htot = t.ha + t.hf + t.hs + t.hb;
        for (int v = first; v < first + nl; v++) begin
            for (int h = 0; h < htot; h++) begin
                if (bump) begin
                    fc_m = (fc_m + 1) % FPS;
                    bump = 1'b0;
                end
                e.h       = h;
                e.v       = v;
                e.fc      = fc_m;
                e.hs      = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs);
                e.vs      = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vs);
                e.ad      = (h < t.ha) && (v < t.va);
                e.nf      = (h == t.ha) && (v == t.va);
                e.chk_rdy = applied && (v == 0) && (h < 2);
                e.rdy     = (h == 1);
                if (e.nf) bump = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_frames(input tmg_t t, input int nframes, input bit applied_first);
        for (int f = 0; f < nframes; f++) begin
            push_lines(t, 0, t.va + t.vf + t.vs + t.vb, applied_first && (f == 0));
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout left=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: one expected pixel popped and compared per cycle.
    always @(negedge clk) begin
        if (chk_en && exp_q.size() != 0) begin
            exp_t e;
            int   oh, ov, ofc;
            bit   ohs, ovs, oad, onf, ordy, oerr, ok;
            e    = exp_q.pop_front();
            oh   = sel ? int'(h2)  : int'(h1);
            ov   = sel ? int'(vc2) : int'(vc1);
            ofc  = sel ? int'(fc2) : int'(fc1);
            ohs  = sel ? hs2  : hs1;
            ovs  = sel ? vs2  : vs1;
            oad  = sel ? ad2  : ad1;
            onf  = sel ? nf2  : nf1;
            ordy = sel ? rdy2 : rdy1;
            oerr = sel ? err2 : err1;
            ok   = (oh == e.h) && (ov == e.v) && (ofc == e.fc) && (ohs == e.hs) &&
                   (ovs == e.vs) && (oad == e.ad) && (onf == e.nf) && !oerr &&
                   (!e.chk_rdy || (ordy == e.rdy));
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL pixel dut%0d got h=%0d v=%0d hs=%0b vs=%0b ad=%0b nf=%0b fc=%0d rdy=%0b err=%0b expected h=%0d v=%0d hs=%0b vs=%0b ad=%0b nf=%0b fc=%0d rdy=%0b(chk=%0b) err=0",
                         sel ? 2 : 1, oh, ov, ohs, ovs, oad, onf, ofc, ordy, oerr,
                         e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc, e.rdy, e.chk_rdy);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tmg_t t720, ta, tb, tc;
        vec_t tbl[10];
        int   n;

        t720 = '{1280, 110, 40, 220, 720, 5, 5, 20};
        ta   = '{6, 1, 2, 1, 3, 1, 1, 1};
        tb   = '{8, 2, 2, 2, 4, 1, 1, 1};
        tc   = '{4, 0, 1, 0, 2, 0, 1, 0};

        tbl[0] = '{hv(8, 2, 0, 2),          vv(4, 1, 1, 1),        1'b1};
        tbl[1] = '{hv(0, 2, 2, 2),          vv(4, 1, 1, 1),        1'b1};
        tbl[2] = '{hv(8, 2, 2, 2),          vv(4, 1, 0, 1),        1'b1};
        tbl[3] = '{hv(8, 2, 2, 2),          vv(0, 1, 1, 1),        1'b1};
        tbl[4] = '{hv(4000, 40, 40, 16),    vv(4, 1, 1, 1),        1'b1};
        tbl[5] = '{hv(4000, 40, 40, 15),    vv(4, 1, 1, 1),        1'b0};
        tbl[6] = '{hv(8, 2, 2, 2),          vv(2000, 20, 20, 8),   1'b1};
        tbl[7] = '{hv(8, 2, 2, 2),          vv(2000, 20, 20, 7),   1'b0};
        tbl[8] = '{hv(4095, 4095, 4095, 4095), vv(4, 1, 1, 1),     1'b1};
        tbl[9] = '{hv(4, 0, 1, 0),          vv(2, 0, 1, 0),        1'b0};

        r1_n = 1'b0; v1_valid = 1'b0; c1_h = '0; c1_v = '0;
        r2_n = 1'b0; v2_valid = 1'b0; c2_h = '0; c2_v = '0;
        repeat (3) @(negedge clk);

        chk("rst_hcount", int'(h1), 0);
        chk("rst_vcount", int'(vc1), 0);
        chk("rst_hs", int'(hs1), 0);
        chk("rst_vs", int'(vs1), 0);
        chk("rst_ad", int'(ad1), 0);
        chk("rst_nf", int'(nf1), 0);
        chk("rst_fc", int'(fc1), 0);
        chk("rst_ready", int'(rdy1), 1);
        chk("rst_err", int'(err1), 0);

        // 720p: two full lines, covering the 1649->0 wrap and line increment.
        sel = 1'b0; fc_m = 0; bump = 1'b0;
        push_lines(t720, 0, 2, 1'b0);
        #1 r1_n = 1'b1; chk_en = 1'b1;
        wait_drain(4000);

        // Legality table: capture, check error pulse and ready, then clear any pending shadow.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 c1_h = tbl[i].ch; c1_v = tbl[i].cv; v1_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_err", i), int'(err1), int'(tbl[i].err));
            chk($sformatf("tbl%0d_ready", i), int'(rdy1), int'(tbl[i].err));
            #1 v1_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_err_clear", i), int'(err1), 0);
            if (!tbl[i].err) begin
                #1 r1_n = 1'b0;
                @(negedge clk);
                chk($sformatf("tbl%0d_ready_after_rst", i), int'(rdy1), 1);
                #1 r1_n = 1'b1;
            end
        end

        // Reset mid-line with a shadow pending: async reset values, then 720p resumes.
        @(negedge clk);
        #1 c1_h = hv(8, 2, 2, 2); c1_v = vv(4, 1, 1, 1); v1_valid = 1'b1;
        @(negedge clk);
        chk("pend_ready", int'(rdy1), 0);
        #1 v1_valid = 1'b0;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #3 r1_n = 1'b0;
        #1;
        chk("async_hcount", int'(h1), 0);
        chk("async_vcount", int'(vc1), 0);
        chk("async_hs", int'(hs1), 0);
        chk("async_ad", int'(ad1), 0);
        chk("async_ready", int'(rdy1), 1);
        fc_m = 0; bump = 1'b0;
        push_lines(t720, 0, 1, 1'b0);
        @(negedge clk);
        #1 r1_n = 1'b1; chk_en = 1'b1;
        wait_drain(2000);
        chk("resume_ready", int'(rdy1), 1);

        // Small mode: reload mid-frame, ignored valid while busy, 60+ frames, zero-porch mode.
        sel = 1'b1; fc_m = 0; bump = 1'b0;
        push_frames(ta, 1, 1'b0);
        @(negedge clk);
        #1 r2_n = 1'b1; chk_en = 1'b1;
        repeat (20) @(negedge clk);
        #1 c2_h = hv(8, 2, 2, 2); c2_v = vv(4, 1, 1, 1); v2_valid = 1'b1;
        push_frames(tb, 60, 1'b1);
        @(negedge clk);
        chk("s_capture_ready", int'(rdy2), 0);
        #1 v2_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 c2_h = hv(8, 2, 0, 2); v2_valid = 1'b1;
        @(negedge clk);
        chk("s_busy_err", int'(err2), 0);
        chk("s_busy_ready", int'(rdy2), 0);
        #1 v2_valid = 1'b0;

        n = 0;
        while (exp_q.size() >= 50 && n < 10000) begin
            @(negedge clk);
            #2;
            n++;
        end
        c2_h = hv(4, 0, 1, 0); c2_v = vv(2, 0, 1, 0); v2_valid = 1'b1;
        push_frames(tc, 2, 1'b1);
        @(negedge clk);
        chk("s_zero_porch_accept", int'(rdy2), 0);
        #1 v2_valid = 1'b0;
        wait_drain(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
